memory_access_controller: RTL and testbench
===========================================

# memory_access_controller

Initiator side of the on-chip data memory port in the MemoryAccess stage. Accepts one load/store request at a time from the pipeline over a valid/ready handshake and checks alignment and the 2 KiB address window. Sequences the memory's negedge read-modify-write protocol (a priming read, then a write) and returns load data or a fault over a second valid/ready handshake.

## Interface
Parameters: none (memory window fixed at 2 KiB, 11-bit address).

- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous, active-high
- reqValid  in  1  pipeline request valid
- reqReady  out  1  controller can accept; high only in IDLE
- reqAddress  in  64  byte address
- reqWriteData  in  64  store data, right-aligned
- reqSize  in  2  00 byte, 01 half, 10 word, 11 double
- reqSignExtended  in  1  load sign-extend (1) or zero-extend (0)
- reqWrite  in  1  1 store, 0 load
- respValid  out  1  response valid
- respReady  in  1  consumer accepts response
- respReadData  out  64  extended load data; 0 for stores and faults
- respMisaligned  out  1  alignment fault, no memory access made
- respAccessFault  out  1  reqAddress[63:11] != 0, no memory access made
- memAddress  out  11  to memory address
- memWriteData  out  64  lane-replicated store data
- memSignExtended  out  1  to memory
- memSize  out  2  to memory
- memWriteEnable  out  1  to memory write enable
- memReadData  in  64  memory combinational read result

## Operation
- Request fields are latched on accept (reqValid && reqReady). Memory-side outputs are registered from the latched copy and held stable from PRIME through WRITE.
- Faults, evaluated at accept:
  - misaligned: size 01 with addr[0] != 0; size 10 with addr[1:0] != 0; size 11 with addr[2:0] != 0
  - access fault: addr[63:11] != 0
  - Both flags are reported independently. Either one sends the request straight to RESP with no memory cycle.
- Store lane replication, required because the memory takes byte n from writeData[8n+7:8n]:
  - size 00: {8{wd[7:0]}}
  - size 01: {4{wd[15:0]}}
  - size 10: {2{wd[31:0]}}
  - size 11: wd
- FSM:
  - IDLE: reqReady=1. On accept, go to RESP if faulted, else to PRIME.
  - PRIME: memWriteEnable=0. The memory latches the target doubleword on this cycle's negedge. At the closing posedge, a load captures memReadData into respReadData and goes to RESP; a store goes to WRITE.
  - WRITE: memWriteEnable=1 for exactly this cycle. The memory merges and commits at the negedge. Then RESP.
  - RESP: respValid=1, outputs held until respReady. Handshake returns to IDLE; respValid drops the next cycle.
- memWriteEnable is high in WRITE only, never in any other state.

## Timing
- Accept on cycle 0, respValid rises on:
  - fault: cycle 1
  - load: cycle 2
  - store: cycle 3
- Minimum request spacing with respReady held high: fault 2, load 3, store 4 cycles. No overlap between requests.
- reqReady is combinational from state (IDLE), with no dependency on reqValid.
- Reset values: state IDLE; respValid, respMisaligned, respAccessFault, memWriteEnable, memSignExtended all 0; respReadData, memWriteData, memAddress, memSize all 0. reqReady is 0 while reset is high.
- Reset mid-operation:
  - A reset sampled at the posedge ending PRIME aborts the request with no write.
  - A reset sampled at the posedge ending WRITE leaves that write committed, since its negedge has already occurred; the response is discarded.
  - memWriteEnable is 0 in the cycle after any reset.
- respReady low holds all resp* outputs bit-stable. reqValid is ignored outside IDLE.

## Test plan
- Byte store, then signed byte load: store addr 0x005, size 00, data 0xA5 -> memWriteData 0xA5A5…A5 and memWriteEnable high exactly one cycle. Then load addr 0x005, signed -> respReadData 0xFFFF_FFFF_FFFF_FFA5 on cycle 2. Bytes 0x000–0x004 and 0x006–0x007 are unchanged.
- Doubleword store, then unsigned word load: store addr 0x010, size 11, data 0x8765_4321_DEAD_BEEF. Load addr 0x014, size 10, unsigned -> 0x0000_0000_8765_4321.
- Misaligned half store: addr 0x003, size 01 -> respMisaligned=1 on cycle 1, memWriteEnable never asserted, memory unchanged.
- Out of window: load addr 0x800 -> respAccessFault=1, respReadData 0. Address 0x807 with size 11 -> both flags set.
- Backpressure: respReady held low 5 cycles after a load -> respValid and respReadData stable. reqValid asserted meanwhile is not accepted.
- Reset mid-store: reset high at the posedge ending PRIME -> no write occurs, all outputs at reset values next cycle, and a subsequent load of that address returns the old data.

Source files
------------

// File: rtl/memory_access_controller.sv
// MemoryAccess-stage initiator for the on-chip data memory: takes one load/store
// at a time, checks alignment and the 2 KiB window, and runs the prime-then-write sequence.
module memory_access_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [63:0] reqAddress,
  input  logic [63:0] reqWriteData,
  input  logic [1:0]  reqSize,
  input  logic        reqSignExtended,
  input  logic        reqWrite,
  output logic        respValid,
  input  logic        respReady,
  output logic [63:0] respReadData,
  output logic        respMisaligned,
  output logic        respAccessFault,
  output logic [10:0] memAddress,
  output logic [63:0] memWriteData,
  output logic        memSignExtended,
  output logic [1:0]  memSize,
  output logic        memWriteEnable,
  input  logic [63:0] memReadData
);

  typedef enum logic [1:0] {IDLE, PRIME, WRITE, RESP} state_t;

  state_t      state;
  logic        is_write;
  logic        accept;
  logic        misaligned;
  logic        access_fault;
  logic [63:0] lane_data;

  assign reqReady     = (state == IDLE) && !reset;
  assign accept       = reqValid && reqReady;
  assign access_fault = |reqAddress[63:11];

  always_comb begin
    misaligned = 1'b0;
    case (reqSize)
      2'b01:   misaligned = reqAddress[0];
      2'b10:   misaligned = |reqAddress[1:0];
      2'b11:   misaligned = |reqAddress[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // The memory picks byte n from lane n, so narrow stores are replicated across all lanes.
  always_comb begin
    lane_data = reqWriteData;
    case (reqSize)
      2'b00:   lane_data = {8{reqWriteData[7:0]}};
      2'b01:   lane_data = {4{reqWriteData[15:0]}};
      2'b10:   lane_data = {2{reqWriteData[31:0]}};
      default: lane_data = reqWriteData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      is_write        <= 1'b0;
      respValid       <= 1'b0;
      respReadData    <= '0;
      respMisaligned  <= 1'b0;
      respAccessFault <= 1'b0;
      memAddress      <= '0;
      memWriteData    <= '0;
      memSignExtended <= 1'b0;
      memSize         <= '0;
      memWriteEnable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_write        <= reqWrite;
            respReadData    <= '0;
            respMisaligned  <= misaligned;
            respAccessFault <= access_fault;
            if (misaligned || access_fault) begin
              respValid <= 1'b1;
              state     <= RESP;
            end else begin
              memAddress      <= reqAddress[10:0];
              memWriteData    <= lane_data;
              memSize         <= reqSize;
              memSignExtended <= reqSignExtended;
              state           <= PRIME;
            end
          end
        end
        // The memory latched the target doubleword at this cycle's negedge.
        PRIME: begin
          if (is_write) begin
            memWriteEnable <= 1'b1;
            state          <= WRITE;
          end else begin
            respReadData <= memReadData;
            respValid    <= 1'b1;
            state        <= RESP;
          end
        end
        WRITE: begin
          memWriteEnable <= 1'b0;
          respValid      <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (respReady) begin
            respValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with a negedge read-modify-write
// memory model; initial byte i holds i ^ 0x5A.
module tb_memory_access_controller;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [63:0] reqAddress;
  logic [63:0] reqWriteData;
  logic [1:0]  reqSize;
  logic        reqSignExtended;
  logic        reqWrite;
  logic        respValid;
  logic        respReady;
  logic [63:0] respReadData;
  logic        respMisaligned;
  logic        respAccessFault;
  logic [10:0] memAddress;
  logic [63:0] memWriteData;
  logic        memSignExtended;
  logic [1:0]  memSize;
  logic        memWriteEnable;
  logic [63:0] memReadData;

  int compared   = 0;
  int mismatched = 0;

  memory_access_controller dut (
    .clk            (clk),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqAddress     (reqAddress),
    .reqWriteData   (reqWriteData),
    .reqSize        (reqSize),
    .reqSignExtended(reqSignExtended),
    .reqWrite       (reqWrite),
    .respValid      (respValid),
    .respReady      (respReady),
    .respReadData   (respReadData),
    .respMisaligned (respMisaligned),
    .respAccessFault(respAccessFault),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memSignExtended(memSignExtended),
    .memSize        (memSize),
    .memWriteEnable (memWriteEnable),
    .memReadData    (memReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  mem [0:2047];
  logic [63:0] latched;
  logic [63:0] shifted;
  int          writes    = 0;
  bit          mem_ready = 1'b0;

  // Memory model: latches the addressed doubleword on a non-write negedge, merges lanes on a write negedge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem_ready = 1'b1;
    end
    if (memWriteEnable) begin
      writes++;
      for (int n = 0; n < 8; n++)
        if (n >= int'(memAddress[2:0]) && n < int'(memAddress[2:0]) + (1 << memSize))
          mem[{memAddress[10:3], 3'(n)}] = memWriteData[8*n +: 8];
    end else begin
      for (int n = 0; n < 8; n++)
        latched[8*n +: 8] = mem[{memAddress[10:3], 3'(n)}];
    end
  end

  always_comb begin
    shifted     = latched >> (8 * memAddress[2:0]);
    memReadData = shifted;
    case (memSize)
      2'b00: memReadData = memSignExtended ? {{56{shifted[7]}},  shifted[7:0]}  : {56'b0, shifted[7:0]};
      2'b01: memReadData = memSignExtended ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
      2'b10: memReadData = memSignExtended ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
      default: memReadData = shifted;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request and waits (bounded) for the response; latency counts cycles after accept.
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] wd, input logic [1:0] size,
                               input logic sext, input logic wr, output int latency,
                               output logic [63:0] seen_wd, output logic [10:0] seen_addr);
    int guard;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    reqValid        = 1'b1;
    reqAddress      = addr;
    reqWriteData    = wd;
    reqSize         = size;
    reqSignExtended = sext;
    reqWrite        = wr;
    @(posedge clk); #1;
    reqValid  = 1'b0;
    seen_wd   = memWriteData;
    seen_addr = memAddress;
    latency   = 1;
    while (!respValid && latency < 10) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic finishResponse(input string tag);
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    checkOutput(tag, 64'(respValid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          w0;
    logic [63:0] wd;
    logic [10:0] ad;

    reset           = 1'b1;
    reqValid        = 1'b0;
    reqAddress      = '0;
    reqWriteData    = '0;
    reqSize         = '0;
    reqSignExtended = 1'b0;
    reqWrite        = 1'b0;
    respReady       = 1'b0;

    @(posedge clk); #1;
    checkOutput("resetReqReady",   64'(reqReady),       64'd0);
    checkOutput("resetRespValid",  64'(respValid),      64'd0);
    checkOutput("resetWriteEn",    64'(memWriteEnable), 64'd0);
    checkOutput("resetReadData",   respReadData,        64'd0);
    checkOutput("resetMemAddress", 64'(memAddress),     64'd0);
    checkOutput("resetWriteData",  memWriteData,        64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("idleReqReady", 64'(reqReady), 64'd1);

    w0 = writes;
    applyStimulus(64'h005, 64'hA5, 2'b00, 1'b0, 1'b1, lat, wd, ad);
    checkOutput("byteStoreLatency",  64'(lat), 64'd3);
    checkOutput("byteStoreLanes",    wd, 64'hA5A5_A5A5_A5A5_A5A5);
    checkOutput("byteStoreAddress",  64'(ad), 64'h005);
    checkOutput("byteStoreWrites",   64'(writes - w0), 64'd1);
    checkOutput("byteStoreData",     respReadData, 64'd0);
    checkOutput("byteStoreFlags",    {62'd0, respMisaligned, respAccessFault}, 64'd0);
    finishResponse("byteStoreDrop");
    checkOutput("mem5",  64'(mem[5]), 64'hA5);
    checkOutput("mem0",  64'(mem[0]), 64'h5A);
    checkOutput("mem4",  64'(mem[4]), 64'h5E);
    checkOutput("mem6",  64'(mem[6]), 64'h5C);
    checkOutput("mem7",  64'(mem[7]), 64'h5D);

    w0 = writes;
    applyStimulus(64'h005, 64'h0, 2'b00, 1'b1, 1'b0, lat, wd, ad);
    checkOutput("byteLoadLatency", 64'(lat), 64'd2);
    checkOutput("byteLoadData",    respReadData, 64'hFFFF_FFFF_FFFF_FFA5);
    checkOutput("byteLoadWrites",  64'(writes - w0), 64'd0);
    finishResponse("byteLoadDrop");

    applyStimulus(64'h010, 64'h8765_4321_DEAD_BEEF, 2'b11, 1'b0, 1'b1, lat, wd, ad);
    checkOutput("dwStoreLatency", 64'(lat), 64'd3);
    checkOutput("dwStoreLanes",   wd, 64'h8765_4321_DEAD_BEEF);
    finishResponse("dwStoreDrop");

    applyStimulus(64'h014, 64'h0, 2'b10, 1'b0, 1'b0, lat, wd, ad);
    checkOutput("wordLoadLatency", 64'(lat), 64'd2);
    checkOutput("wordLoadData",    respReadData, 64'h0000_0000_8765_4321);
    finishResponse("wordLoadDrop");

    applyStimulus(64'h010, 64'h0, 2'b01, 1'b1, 1'b0, lat, wd, ad);
    checkOutput("halfLoadData", respReadData, 64'hFFFF_FFFF_FFFF_BEEF);
    finishResponse("halfLoadDrop");

    w0 = writes;
    applyStimulus(64'h003, 64'h1234, 2'b01, 1'b0, 1'b1, lat, wd, ad);
    checkOutput("misLatency",   64'(lat), 64'd1);
    checkOutput("misFlag",      64'(respMisaligned),  64'd1);
    checkOutput("misAccess",    64'(respAccessFault), 64'd0);
    checkOutput("misData",      respReadData, 64'd0);
    checkOutput("misWrites",    64'(writes - w0), 64'd0);
    checkOutput("misMem2",      64'(mem[2]), 64'h58);
    checkOutput("misMem3",      64'(mem[3]), 64'h59);
    finishResponse("misDrop");

    applyStimulus(64'h800, 64'h0, 2'b00, 1'b0, 1'b0, lat, wd, ad);
    checkOutput("oowLatency",   64'(lat), 64'd1);
    checkOutput("oowAccess",    64'(respAccessFault), 64'd1);
    checkOutput("oowMisalign",  64'(respMisaligned),  64'd0);
    checkOutput("oowData",      respReadData, 64'd0);
    finishResponse("oowDrop");

    applyStimulus(64'h807, 64'h0, 2'b11, 1'b0, 1'b0, lat, wd, ad);
    checkOutput("bothFlags", {62'd0, respMisaligned, respAccessFault}, 64'd3);
    finishResponse("bothDrop");

    w0 = writes;
    applyStimulus(64'h014, 64'h0, 2'b10, 1'b0, 1'b0, lat, wd, ad);
    reqValid     = 1'b1;
    reqAddress   = 64'h005;
    reqWriteData = 64'h77;
    reqSize      = 2'b00;
    reqWrite     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bpValid",    64'(respValid), 64'd1);
      checkOutput("bpData",     respReadData,   64'h0000_0000_8765_4321);
      checkOutput("bpReqReady", 64'(reqReady),  64'd0);
    end
    reqValid = 1'b0;
    checkOutput("bpWrites", 64'(writes - w0), 64'd0);
    finishResponse("bpDrop");

    w0 = writes;
    reqValid        = 1'b1;
    reqAddress      = 64'h020;
    reqWriteData    = 64'hCAFE_F00D;
    reqSize         = 2'b10;
    reqSignExtended = 1'b0;
    reqWrite        = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstWriteEn",   64'(memWriteEnable), 64'd0);
    checkOutput("rstRespValid", 64'(respValid),      64'd0);
    checkOutput("rstAddress",   64'(memAddress),     64'd0);
    checkOutput("rstWriteData", memWriteData,        64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstWriteEnAfter", 64'(memWriteEnable), 64'd0);
    checkOutput("rstReqReady",     64'(reqReady),       64'd1);
    checkOutput("rstWrites",       64'(writes - w0),    64'd0);
    applyStimulus(64'h020, 64'h0, 2'b10, 1'b0, 1'b0, lat, wd, ad);
    checkOutput("rstOldData", respReadData, 64'h0000_0000_7978_7B7A);
    finishResponse("rstDrop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
